// File: rtl/am2910_stack_ctrl.sv
// am2910_stack_ctrl: return-address LIFO controller driving an external sync-read stack RAM.
// Define AM2910_STACK_FLAGS_EN to build the sticky ovf/unf flags (tied low otherwise).
module am2910_stack_ctrl #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  logic [WIDTH-1:0] din,
    output logic             ready,
    output logic [WIDTH-1:0] tos,
    output logic             tos_valid,
    output logic [AW:0]      sp,
    output logic             full,
    output logic             empty,
    output logic             ovf,
    output logic             unf,
    output logic             mem_we,
    output logic [AW-1:0]    mem_addr,
    output logic [WIDTH-1:0] mem_din,
    input  logic [WIDTH-1:0] mem_dout
);

    typedef enum logic {IDLE, REFILL} state_t;

    localparam logic [AW:0]   SP_FULL  = (AW+1)'(DEPTH);
    localparam logic [AW:0]   SP_ONE   = (AW+1)'(1);
    localparam logic [AW-1:0] ADDR_TOP = AW'(DEPTH-1);

    state_t           state;
    logic [AW:0]      spReg;
    logic [WIDTH-1:0] tosReg;
    logic [AW-1:0]    addrHold;

    logic accept, isFull, isEmpty, spGe2;
    logic doPush, doReplace, doPop;
    logic [AW-1:0] topAddr, readAddr;

    assign accept    = (state == IDLE) && !clear;
    assign isFull    = (spReg == SP_FULL);
    assign isEmpty   = (spReg == '0);
    assign spGe2     = (spReg > SP_ONE);
    assign doReplace = accept && push && pop && !isEmpty;
    assign doPush    = accept && push && !doReplace;
    assign doPop     = accept && pop && !push;

    // Modulo-DEPTH arithmetic on the low bits gives the right slot even when sp==DEPTH.
    assign topAddr  = spReg[AW-1:0] - AW'(1);
    assign readAddr = spReg[AW-1:0] - AW'(2);

    assign mem_we  = !rst && (doPush || doReplace);
    assign mem_din = din;

    always_comb begin
        mem_addr = addrHold;
        if (rst)
            mem_addr = '0;
        else if (doReplace)
            mem_addr = topAddr;
        else if (doPush)
            mem_addr = isFull ? ADDR_TOP : spReg[AW-1:0];
        else if (doPop && spGe2)
            mem_addr = readAddr;
    end

    // Popping below two entries needs the new top fetched from RAM, hence the REFILL cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            spReg    <= '0;
            tosReg   <= '0;
            addrHold <= '0;
        end else begin
            addrHold <= mem_addr;
            if (clear) begin
                state  <= IDLE;
                spReg  <= '0;
                tosReg <= '0;
            end else if (state == REFILL) begin
                tosReg <= mem_dout;
                state  <= IDLE;
            end else if (doReplace) begin
                tosReg <= din;
            end else if (doPush) begin
                tosReg <= din;
                if (!isFull)
                    spReg <= spReg + SP_ONE;
            end else if (doPop) begin
                if (spGe2) begin
                    spReg <= spReg - SP_ONE;
                    state <= REFILL;
                end else if (!isEmpty) begin
                    spReg  <= '0;
                    tosReg <= '0;
                end
            end
        end
    end

`ifdef AM2910_STACK_FLAGS_EN
    logic ovfReg, unfReg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovfReg <= 1'b0;
            unfReg <= 1'b0;
        end else if (clear) begin
            ovfReg <= 1'b0;
            unfReg <= 1'b0;
        end else begin
            if (doPush && isFull && !pop)
                ovfReg <= 1'b1;
            if (doPop && isEmpty)
                unfReg <= 1'b1;
        end
    end

    assign ovf = ovfReg;
    assign unf = unfReg;
`else
    assign ovf = 1'b0;
    assign unf = 1'b0;
`endif

    assign ready     = (state == IDLE);
    assign tos_valid = (state == IDLE) && !isEmpty;
    assign tos       = tosReg;
    assign sp        = spReg;
    assign full      = isFull;
    assign empty     = isEmpty;

endmodule
